// File: rtl/led_frame_tx.sv
// led_frame_tx: FIFO-buffered transmitter that sends each queued word as a Manchester-coded LED frame
module led_frame_tx #(
  parameter int FRAME_SIZE    = 16,
  parameter int DEPTH         = 4,
  parameter int BIT_TICKS     = 4,
  parameter int PREAMBLE_BITS = 4,
  parameter int PARITY_EN     = 1,
  parameter int GAP_TICKS     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [FRAME_SIZE-1:0]      data,
  input  logic                       push,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       busy,
  output logic                       led,
  output logic                       irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2((BIT_TICKS > GAP_TICKS ? BIT_TICKS : GAP_TICKS) + 1);
  localparam int BW = $clog2((FRAME_SIZE > PREAMBLE_BITS ? FRAME_SIZE : PREAMBLE_BITS) + 1);
  typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, PARITY, GAP} state_t;
  state_t state, state_n;
  logic [FRAME_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FRAME_SIZE-1:0] shreg;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_cnt;
  logic par, pop, wr, bit_end, b, led_n, irq_n;
  assign full    = level == LW'(DEPTH);
  assign busy    = state != IDLE;
  assign pop     = state == IDLE && enable && level != '0;
  assign wr      = push && (!full || pop);
  assign bit_end = state != GAP && tick == TW'(BIT_TICKS - 1);
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(wr);
      rd_ptr   <= rd_ptr + AW'(pop);
      level    <= level + LW'(wr) - LW'(pop);
      overflow <= overflow | (push & ~wr);
    end
  // tick and bit counters restart on every state change; the LED is one cycle behind the state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      led     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= (state_n != state || bit_end) ? '0 : tick + 1'b1;
      bit_cnt <= state_n != state ? '0 : bit_cnt + BW'(bit_end);
      shreg   <= pop ? mem[rd_ptr] : (state == DATA && bit_end) ? shreg << 1 : shreg;
      par     <= pop ? ^mem[rd_ptr] : par;
      led     <= led_n;
      irq     <= irq_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = pop ? PREAMBLE : IDLE;
      PREAMBLE: state_n = bit_end && bit_cnt == BW'(PREAMBLE_BITS - 1) ? START : PREAMBLE;
      START:    state_n = bit_end ? DATA : START;
      DATA:     state_n = !(bit_end && bit_cnt == BW'(FRAME_SIZE - 1)) ? DATA : PARITY_EN != 0 ? PARITY : GAP;
      PARITY:   state_n = bit_end ? GAP : PARITY;
      GAP:      state_n = tick == TW'(GAP_TICKS - 1) ? IDLE : GAP;
      default:  state_n = IDLE;
    endcase
    b     = state == PREAMBLE ? ~bit_cnt[0] : state == DATA ? shreg[FRAME_SIZE-1] : par;
    led_n = state == START || ((state == PREAMBLE || state == DATA || state == PARITY) &&
            (tick < TW'(BIT_TICKS / 2) ? ~b : b));
    irq_n = state == GAP && state_n == IDLE;
  end
endmodule

// File: tb/tb_led_frame_tx.sv
// tb_led_frame_tx: directed checks of framing, parity, FIFO limits, back-to-back, reset and enable behaviour
module tb_led_frame_tx;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, push = 1'b0, np_push = 1'b0;
  logic [15:0] data = '0, np_data = '0;
  logic full, overflow, busy, led, irq;
  logic np_full, np_overflow, np_busy, np_led, np_irq;
  logic [2:0] level, np_level;
  int checks = 0, errors = 0;
  typedef struct {
    logic        push;
    logic        enable;
    logic [15:0] data;
    logic [5:0]  exp;
  } vec_t;
  vec_t tbl[7];
  logic [15:0] words[5];
  always #5 clock = ~clock;
  led_frame_tx dut (
    .clock(clock), .reset(reset), .enable(enable), .data(data), .push(push),
    .full(full), .level(level), .overflow(overflow), .busy(busy), .led(led), .irq(irq)
  );
  led_frame_tx #(.PARITY_EN(0)) np (
    .clock(clock), .reset(reset), .enable(enable), .data(np_data), .push(np_push),
    .full(np_full), .level(np_level), .overflow(np_overflow), .busy(np_busy), .led(np_led), .irq(np_irq)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [5:0] st();
    return {full, level, overflow, busy};
  endfunction
  // call right after the pop edge; samples the whole frame up to and including the irq cycle
  task automatic frame_check(input logic [15:0] w, input bit nopar, input string name);
    logic q[$];
    logic bits[$];
    int bad = 0, irq_at = -1, irqs = 0;
    for (int i = 0; i < 4; i++) bits.push_back(i % 2 == 0);
    foreach (bits[i]) begin
      q.push_back(~bits[i]); q.push_back(~bits[i]); q.push_back(bits[i]); q.push_back(bits[i]);
    end
    for (int i = 0; i < 4; i++) q.push_back(1'b1);
    bits.delete();
    for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
    if (!nopar) bits.push_back(^w);
    foreach (bits[i]) begin
      q.push_back(~bits[i]); q.push_back(~bits[i]); q.push_back(bits[i]); q.push_back(bits[i]);
    end
    for (int i = 0; i < 8; i++) q.push_back(1'b0);
    for (int j = 0; j < q.size(); j++) begin
      step();
      if ((nopar ? np_led : led) !== q[j]) bad++;
      if ((nopar ? np_irq : irq) === 1'b1) begin
        irqs++;
        irq_at = j;
      end
    end
    chk({name, " led"}, bad, 0);
    chk({name, " irq_pos"}, irq_at, q.size() - 1);
    chk({name, " irq_cnt"}, irqs, 1);
    chk({name, " idle"}, nopar ? np_busy : busy, 0);
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h1234, {1'b0, 3'd1, 1'b0, 1'b0}};
    tbl[1] = '{1'b1, 1'b0, 16'h8001, {1'b0, 3'd2, 1'b0, 1'b0}};
    tbl[2] = '{1'b1, 1'b0, 16'h00FF, {1'b0, 3'd3, 1'b0, 1'b0}};
    tbl[3] = '{1'b1, 1'b0, 16'hC3A5, {1'b1, 3'd4, 1'b0, 1'b0}};
    tbl[4] = '{1'b1, 1'b0, 16'hDEAD, {1'b1, 3'd4, 1'b1, 1'b0}};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, {1'b1, 3'd4, 1'b1, 1'b0}};
    tbl[6] = '{1'b1, 1'b1, 16'h7E81, {1'b1, 3'd4, 1'b1, 1'b1}};
    words = '{16'h1234, 16'h8001, 16'h00FF, 16'hC3A5, 16'h7E81};
    step(); step();
    chk("reset_status", {st(), led, irq}, 0);
    reset = 1'b0;
    step();
    enable = 1'b1; data = 16'hF4B6; push = 1'b1;
    step();
    push = 1'b0;
    chk("t1_queued", st(), {1'b0, 3'd1, 1'b0, 1'b0});
    step();
    chk("t1_popped", st(), {1'b0, 3'd0, 1'b0, 1'b1});
    chk("t1_led_first", led, 0);
    frame_check(16'hF4B6, 1'b0, "t1");
    data = 16'h0001; push = 1'b1;
    step();
    push = 1'b0;
    step();
    frame_check(16'h0001, 1'b0, "t2_par");
    np_data = 16'h0001; np_push = 1'b1;
    step();
    np_push = 1'b0;
    step();
    chk("t2_np_busy", np_busy, 1);
    frame_check(16'h0001, 1'b1, "t2_nopar");
    enable = 1'b0;
    foreach (tbl[i]) begin
      push = tbl[i].push; enable = tbl[i].enable; data = tbl[i].data;
      step();
      chk($sformatf("t3_vec%0d", i), st(), tbl[i].exp);
    end
    push = 1'b0;
    foreach (words[i]) begin
      if (i > 0) begin
        chk($sformatf("t4_gap%0d", i), {busy, led}, 0);
        step();
        chk($sformatf("t4_next%0d", i), busy, 1);
      end
      frame_check(words[i], 1'b0, $sformatf("t3_frame%0d", i));
    end
    repeat (10) step();
    chk("t3_drained", st(), {1'b0, 3'd0, 1'b1, 1'b0});
    enable = 1'b0;
    data = 16'hA4C3; push = 1'b1;
    step();
    data = 16'h0F0F;
    step();
    push = 1'b0; enable = 1'b1;
    step();
    chk("t5_level", level, 1);
    repeat (49) step();
    chk("t5_pre_led", {busy, led}, 2'b11);
    reset = 1'b1;
    #1;
    chk("t5_async", {led, busy, level, overflow}, 0);
    step();
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 120; i++) begin
        step();
        if (irq === 1'b1 || busy === 1'b1) seen++;
      end
      chk("t5_quiet", seen, 0);
    end
    data = 16'h3C5A; push = 1'b1;
    step();
    push = 1'b0;
    step();
    frame_check(16'h3C5A, 1'b0, "t5_fresh");
    data = 16'h5555; push = 1'b1;
    step();
    data = 16'h9009;
    step();
    push = 1'b0; enable = 1'b0;
    chk("t6_start", {busy, level}, {1'b1, 3'd1});
    frame_check(16'h5555, 1'b0, "t6_f1");
    repeat (20) step();
    chk("t6_hold", {busy, level}, {1'b0, 3'd1});
    enable = 1'b1;
    step();
    chk("t6_resume", {busy, level}, {1'b1, 3'd0});
    frame_check(16'h9009, 1'b0, "t6_f2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
